// File: rtl/tinyml_hw_accel_pkg.sv
// Shared definitions for the TinyML accelerator output framer:
// write-FSM state encoding, default frame size and statistics width.
package tinyml_hw_accel_pkg;

  // Write-side framing FSM
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } wr_state_t;

  // 96x96 grayscale frame packed four pixels per word
  localparam int FRAME_WORDS_DEFAULT = 2304;

  // Width of frame/drop statistics counters (wrap naturally)
  localparam int STAT_W = 16;

endpackage

// File: rtl/tinyml_hw_accel_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// The head register mirrors the entry at the read pointer, so total
// capacity is exactly DEPTH. A word written into an empty FIFO shows up
// on dout/valid the next cycle. Read and write may fire together in any
// occupancy, including full (the read frees the slot that cycle).
module tinyml_hw_accel_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_n, rd_ptr_n;
  logic             wr_fire, rd_fire;
  logic             head_is_new;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_fire  = rd && !empty;
  assign wr_fire  = wr && (!full || rd_fire);
  assign wr_ptr_n = wr_fire ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_ptr_n = rd_fire ? (rd_ptr + PTR_ONE) : rd_ptr;

  // Next head is the word being written right now when every older
  // entry has been consumed; otherwise it is already in storage.
  assign head_is_new = wr_fire && (rd_ptr_n == wr_ptr);

  // Storage array write (no reset needed, validity tracked by pointers)
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers and registered head; head only reloads when occupancy moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      valid  <= (wr_ptr_n != rd_ptr_n);
      if (wr_fire || rd_fire)
        dout <= head_is_new ? din : mem[rd_ptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/tinyml_hw_accel_out_framer.sv
// Output framer: tags the final word of each frame, buffers {last,data}
// toward a DMA valid/ready port, flags dropped words and keeps stats.
// Optional macro TINYML_HW_ACCEL_OUT_FRAMER_STATS_EN builds the
// frame/drop counters; without it both ports are tied to zero.
module tinyml_hw_accel_out_framer
  import tinyml_hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [STAT_W-1:0]     frame_count,
  output logic [STAT_W-1:0]     drop_count
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  wr_state_t             state;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         cnt_eff;
  logic                  accept, push, is_last, drop, handshake;
  logic                  fifo_full, fifo_empty, fifo_valid;
  logic [DATA_WIDTH:0]   fifo_dout;

  // frame_start opens the frame in the same cycle, so a coincident word
  // is word 0 of the new frame.
  assign accept    = frame_start || (state == ST_ACTIVE);
  assign cnt_eff   = frame_start ? '0 : wr_cnt;
  assign is_last   = (cnt_eff == LAST_IDX);
  assign push      = in_valid && accept;
  assign handshake = out_ready && !fifo_empty;
  // A full FIFO still takes the word if the head leaves this cycle
  assign drop      = push && fifo_full && !handshake;

  // Write FSM, word counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (frame_start) begin
        state    <= ST_ACTIVE;
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end
      if (push) begin
        wr_cnt <= cnt_eff + CNT_ONE;
        if (is_last) state <= ST_IDLE;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  tinyml_hw_accel_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .din   ({is_last, in_data}),
    .rd    (out_ready),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = fifo_valid;
  assign out_data   = fifo_dout[DATA_WIDTH-1:0];
  assign out_last   = fifo_dout[DATA_WIDTH] && fifo_valid;
  assign frame_done = out_valid && out_ready && out_last;

`ifdef TINYML_HW_ACCEL_OUT_FRAMER_STATS_EN
  // Statistics: frames delivered and words dropped, both wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 1'b1;
      if (drop)       drop_count  <= drop_count + 1'b1;
    end
  end
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: doc/tinyml_hw_accel_out_framer.md
TINYML_HW_ACCEL_OUT_FRAMER -- requirements
Module: tinyml_hw_accel_out_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the packed word (four 8-bit grayscale pixels).
REQ-002 SHALL have parameter FRAME_WORDS, default 2304: packed words per frame (96x96/4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 64: buffer entries, power of two, minimum 4.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port frame_start, input, 1: single-cycle pulse that opens a new frame.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: packed word from the pack stage.
REQ-008 SHALL have port in_valid, input, 1: in_data qualifier; there is no backpressure on the input side.
REQ-009 SHALL have port out_data, output, DATA_WIDTH: word presented to DMA.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): valid/ready handshake.
REQ-011 SHALL have port out_last, output, 1: marks the final word of a frame while out_valid is high.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse on the handshake of the last word.
REQ-013 SHALL have port overflow, output, 1: sticky flag indicating an input word was dropped.
REQ-014 SHALL have ports frame_count (output, 16) and drop_count (output, 16): statistics counters.

Function
REQ-015 Write FSM SHALL have two states, IDLE and ACTIVE.
REQ-016 A frame_start pulse in any state SHALL select ACTIVE, clear the write counter to 0, and clear overflow.
REQ-017 In IDLE, in_valid words SHALL be discarded without setting overflow.
REQ-018 In ACTIVE, each in_valid word SHALL increment the write counter, whether the word is stored or dropped.
REQ-019 In ACTIVE, the word with write counter = FRAME_WORDS-1 SHALL be stored with last=1, and the FSM SHALL then return to IDLE.
REQ-020 The FIFO SHALL store {last, data}, DATA_WIDTH+1 bits per entry.
REQ-021 If in_valid arrives in ACTIVE while the FIFO is full, the word SHALL be dropped, overflow SHALL be set to 1, and drop_count SHALL increment.
REQ-022 A dropped final word SHALL lose its last marker; the frame then produces no out_last, and recovery is via the next frame_start.
REQ-023 If frame_start and in_valid occur in the same cycle, that word SHALL be word 0 of the new frame.
REQ-024 A frame_start arriving mid-frame SHALL leave the already-buffered words of the old frame in the FIFO, with no last flag appended.
REQ-025 The output SHALL use registered first-word-fall-through: a word written into an empty FIFO in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-026 out_data, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 A write and a read in the same cycle SHALL both succeed, including when the FIFO is full (the read frees the slot in that cycle) and when it is empty or has a single entry.
REQ-028 frame_done SHALL pulse for one cycle in the cycle where out_valid, out_ready and out_last are all high.
REQ-029 frame_count SHALL increment on each frame_done pulse.
REQ-030 frame_count and drop_count SHALL both wrap modulo 2^16.
REQ-031 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide: full when the MSBs differ and the remaining bits are equal, empty when all bits are equal.

Reset
REQ-032 While rst=1, asynchronously, the FSM SHALL be IDLE; pointers, write counter, frame_count and drop_count SHALL be 0; and out_valid, out_last, frame_done and overflow SHALL be 0.
REQ-033 out_data SHALL reset to 0.
REQ-034 A reset asserted mid-frame SHALL discard all buffered words.

Configuration
REQ-035 Macro TINYML_HW_ACCEL_OUT_FRAMER_STATS_EN, when defined, SHALL implement frame_count and drop_count as specified in REQ-029, REQ-030 and REQ-021.
REQ-036 Without TINYML_HW_ACCEL_OUT_FRAMER_STATS_EN, both ports SHALL remain present, be tied to 0, and no counter logic SHALL be built.

Structure
REQ-037 Package tinyml_hw_accel_pkg SHALL hold the write-FSM state encoding, the default FRAME_WORDS value (2304), and the statistics counter width (16).
REQ-038 Buffering SHALL be a sub-module named tinyml_hw_accel_sync_fifo (parameters WIDTH and DEPTH) with full and empty outputs.
REQ-039 Framing, the FSM and the counters SHALL reside in the top module.

Verification (FRAME_WORDS=8, FIFO_DEPTH=4, macro defined)
REQ-040 Scenario "nominal frame": frame_start, then 8 consecutive in_valid words 0x00000001..0x00000008, out_ready=1 -> 8 output words in order; out_last=1 on 0x00000008 only; frame_done pulses once; frame_count=1; overflow=0.
REQ-041 Scenario "backpressure overflow": out_ready=0 while 6 words are written -> 4 words buffered; overflow=1; drop_count=2; after out_ready=1, words 1-4 are output with no out_last.
REQ-042 Scenario "stall hold": out_ready toggled 0/1 every cycle during a frame -> out_data stable during each stall; all 8 words delivered; frame_done=1 once.
REQ-043 Scenario "mid-frame restart": frame_start after 3 words, then 8 words 0xA1..0xA8 -> output sequence is 3 old words, then 0xA1..0xA8 with out_last on 0xA8; overflow=0.
REQ-044 Scenario "IDLE discard": 5 in_valid words with no frame_start -> out_valid stays 0; overflow=0; drop_count=0.
REQ-045 Scenario "async reset mid-frame": rst pulsed high for 1 cycle after 4 buffered words -> out_valid=0 immediately with no clock edge; counters=0; the following frame passes nominally.
